// File: rtl/screen_pkg.sv
// Shared constants and clear-engine state encoding for the banked screen buffer.
package screen_pkg;

  localparam int unsigned SCREEN_DEPTH     = 6912;
  localparam int unsigned SCREEN_ATTR_BASE = 6144;
  localparam logic [7:0]  DEFAULT_ATTR     = 8'h38;

  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_CLEAR = 2'd1,
    CLR_DONE  = 2'd2
  } clr_state_e;

endpackage

// File: rtl/screen_clear_fsm.sv
// Clear engine: sweeps one bank writing blank pixels then the default attribute.
module screen_clear_fsm
  import screen_pkg::*;
#(
  parameter int unsigned   DATA_W     = 8,
  parameter int unsigned   ADDR_W     = 13,
  parameter int unsigned   DEPTH      = SCREEN_DEPTH,
  parameter int unsigned   ATTR_BASE  = SCREEN_ATTR_BASE,
  parameter int unsigned   BANK_W     = 1,
  parameter logic [DATA_W-1:0] CLEAR_ATTR = DATA_W'(DEFAULT_ATTR)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr_req,
  input  logic [BANK_W-1:0] clr_bank,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              wr_ready,
  output logic              clr_wr_en_c,
  output logic [BANK_W-1:0] clr_wr_bank_c,
  output logic [ADDR_W-1:0] clr_wr_addr_c,
  output logic [DATA_W-1:0] clr_wr_data_c
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ATTR_ADDR = ADDR_W'(ATTR_BASE);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [BANK_W-1:0] bank_q, bank_d;

  // Next-state logic and the generated write for the current sweep position.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bank_d        = bank_q;
    clr_wr_en_c   = (state_q == CLR_CLEAR);
    clr_wr_bank_c = bank_q;
    clr_wr_addr_c = cnt_q;
    clr_wr_data_c = (cnt_q < ATTR_ADDR) ? '0 : CLEAR_ATTR;
    unique case (state_q)
      CLR_IDLE: begin
        if (clr_req) begin
          bank_d  = clr_bank;
          cnt_d   = '0;
          state_d = CLR_CLEAR;
        end
      end
      CLR_CLEAR: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = CLR_DONE;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      CLR_DONE: state_d = CLR_IDLE;
      default:  state_d = CLR_IDLE;
    endcase
  end

  // State register; status outputs registered from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= CLR_IDLE;
      cnt_q    <= '0;
      bank_q   <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
      wr_ready <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bank_q   <= bank_d;
      clr_busy <= (state_d == CLR_CLEAR);
      clr_done <= (state_d == CLR_DONE);
      wr_ready <= (state_d != CLR_CLEAR);
    end
  end

endmodule

// File: rtl/screen_buffer_banked.sv
// Multi-bank ZX screen buffer with frame-synchronised bank switch, read bypass and clear engine.
module screen_buffer_banked
  import screen_pkg::*;
#(
  parameter int unsigned   DATA_W     = 8,
  parameter int unsigned   ADDR_W     = 13,
  parameter int unsigned   DEPTH      = SCREEN_DEPTH,
  parameter int unsigned   ATTR_BASE  = SCREEN_ATTR_BASE,
  parameter int unsigned   BANK_W     = 1,
  parameter logic [DATA_W-1:0] CLEAR_ATTR = DATA_W'(DEFAULT_ATTR)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic [BANK_W-1:0] disp_bank_req,
  input  logic              frame_start,
  output logic [BANK_W-1:0] disp_bank,
  input  logic              clr_req,
  input  logic [BANK_W-1:0] clr_bank,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam int unsigned BANKS = 1 << BANK_W;

  logic [DATA_W-1:0] mem [BANKS][DEPTH];

  logic              clr_wr_en_c;
  logic [BANK_W-1:0] clr_wr_bank_c;
  logic [ADDR_W-1:0] clr_wr_addr_c;
  logic [DATA_W-1:0] clr_wr_data_c;

  logic              mem_we_c;
  logic [BANK_W-1:0] mem_bank_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_data_c;
  logic [DATA_W-1:0] rd_word_c;

  screen_clear_fsm #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .DEPTH      (DEPTH),
    .ATTR_BASE  (ATTR_BASE),
    .BANK_W     (BANK_W),
    .CLEAR_ATTR (CLEAR_ATTR)
  ) u_clear (
    .clk           (clk),
    .reset_n       (reset_n),
    .clr_req       (clr_req),
    .clr_bank      (clr_bank),
    .clr_busy      (clr_busy),
    .clr_done      (clr_done),
    .wr_ready      (wr_ready),
    .clr_wr_en_c   (clr_wr_en_c),
    .clr_wr_bank_c (clr_wr_bank_c),
    .clr_wr_addr_c (clr_wr_addr_c),
    .clr_wr_data_c (clr_wr_data_c)
  );

  // Write port mux: clear engine first, then an accepted in-range CPU write.
  always_comb begin
    mem_we_c   = 1'b0;
    mem_bank_c = wr_bank;
    mem_addr_c = wr_addr;
    mem_data_c = wr_data;
    if (clr_wr_en_c) begin
      mem_we_c   = 1'b1;
      mem_bank_c = clr_wr_bank_c;
      mem_addr_c = clr_wr_addr_c;
      mem_data_c = clr_wr_data_c;
    end else if (wr_en && wr_ready && (32'(wr_addr) < DEPTH)) begin
      mem_we_c = 1'b1;
    end
  end

  // Storage array; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[mem_bank_c][mem_addr_c] <= mem_data_c;
    end
  end

  // Read word with same-cycle write bypass; out-of-range reads return zero.
  always_comb begin
    rd_word_c = '0;
    if (32'(rd_addr) < DEPTH) begin
      if (mem_we_c && (mem_bank_c == disp_bank) && (mem_addr_c == rd_addr)) begin
        rd_word_c = mem_data_c;
      end else begin
        rd_word_c = mem[disp_bank][rd_addr];
      end
    end
  end

  // Registered read port; data holds when no read is requested.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_word_c;
      end
    end
  end

  // Display bank only changes at a frame boundary to avoid tearing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      disp_bank <= '0;
    end else if (frame_start) begin
      disp_bank <= disp_bank_req;
    end
  end

endmodule

// File: tb/tb_screen_buffer_banked.sv
// Scoreboard bench for screen_buffer_banked.
module tb_screen_buffer_banked;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_en;
  logic [0:0]  wr_bank;
  logic [12:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic        rd_en;
  logic [12:0] rd_addr;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [0:0]  disp_bank_req;
  logic        frame_start;
  logic [0:0]  disp_bank;
  logic        clr_req;
  logic [0:0]  clr_bank;
  logic        clr_busy;
  logic        clr_done;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  model[int];
  logic        cur_disp;
  logic [7:0]  exp_v;

  screen_buffer_banked dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .wr_en         (wr_en),
    .wr_bank       (wr_bank),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_ready      (wr_ready),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .disp_bank_req (disp_bank_req),
    .frame_start   (frame_start),
    .disp_bank     (disp_bank),
    .clr_req       (clr_req),
    .clr_bank      (clr_bank),
    .clr_busy      (clr_busy),
    .clr_done      (clr_done)
  );

  always #5 clk = ~clk;

  function automatic int key(input logic b, input logic [12:0] a);
    return int'(b) * 8192 + int'(a);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic b, input logic [12:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_bank = b; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
    if (a < 13'd6912) model[key(b, a)] = d;
  endtask

  task automatic issue_read(input logic [12:0] a, input logic [7:0] e);
    rd_en = 1'b1; rd_addr = a;
    exp_q.push_back(e);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic set_disp(input logic b);
    disp_bank_req = b; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    cur_disp = b;
  endtask

  // Same-cycle write and read of one address; expectation from the model.
  task automatic write_and_read(input logic b, input logic [12:0] a, input logic [7:0] d);
    logic [7:0] e;
    if (a >= 13'd6912)    e = 8'h00;
    else if (b == cur_disp) e = d;
    else                  e = model[key(cur_disp, a)];
    wr_en = 1'b1; wr_bank = b; wr_addr = a; wr_data = d;
    rd_en = 1'b1; rd_addr = a;
    exp_q.push_back(e);
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    if (a < 13'd6912) model[key(b, a)] = d;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    wr_en = 1'b0; wr_bank = '0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0; disp_bank_req = '0; frame_start = 1'b0;
    clr_req = 1'b0; clr_bank = '0;
    cur_disp = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    n_checks++;
    if ({rd_valid, rd_data, disp_bank, clr_busy, clr_done, wr_ready} !== 13'b0_00000000_0_0_0_1) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%0b data=%02h disp=%0d busy=%0b done=%0b ready=%0b, need 0 00 0 0 0 1",
               rd_valid, rd_data, disp_bank, clr_busy, clr_done, wr_ready);
    end
  endtask

  task automatic test_write_read();
    cpu_write(1'b0, 13'h0000, 8'hAA);
    issue_read(13'h0000, model[key(1'b0, 13'h0000)]);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== exp_v) begin
      n_fail++;
      $display("FAIL basic_read: valid=%0b data=%02h, need 1 %02h", rd_valid, rd_data, exp_v);
    end
    tick();
    n_checks++;
    if (rd_valid !== 1'b0 || rd_data !== 8'hAA) begin
      n_fail++;
      $display("FAIL read_hold: valid=%0b data=%02h, need 0 aa", rd_valid, rd_data);
    end
    cpu_write(1'b0, 13'd7000, 8'hFF);
    issue_read(13'd7000, 8'h00);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== exp_v) begin
      n_fail++;
      $display("FAIL out_of_range_read: valid=%0b data=%02h, need 1 %02h", rd_valid, rd_data, exp_v);
    end
  endtask

  task automatic test_bank_switch();
    int bad = 0;
    cpu_write(1'b0, 13'd5, 8'h5A);
    cpu_write(1'b1, 13'd5, 8'hA5);
    disp_bank_req = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (disp_bank !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL no_switch_without_frame: disp_bank moved in %0d cycles, need 0", bad);
    end
    frame_start = 1'b1; rd_en = 1'b1; rd_addr = 13'd5;
    exp_q.push_back(model[key(1'b0, 13'd5)]);
    tick();
    frame_start = 1'b0; rd_en = 1'b0; cur_disp = 1'b1;
    exp_v = exp_q.pop_front();
    n_checks++;
    if (rd_data !== exp_v || disp_bank !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_switch: data=%02h disp=%0d, need %02h 1", rd_data, disp_bank, exp_v);
    end
    issue_read(13'd5, model[key(1'b1, 13'd5)]);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== exp_v) begin
      n_fail++;
      $display("FAIL read_new_bank: valid=%0b data=%02h, need 1 %02h", rd_valid, rd_data, exp_v);
    end
  endtask

  task automatic test_bypass();
    cpu_write(1'b1, 13'h1800, 8'h11);
    cpu_write(1'b0, 13'h1800, 8'h22);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) set_disp(1'b0);
      case (i)
        0:       write_and_read(1'b1, 13'h1800, 8'h47);
        1:       write_and_read(1'b1, 13'h1800, 8'h55);
        default: write_and_read(1'b0, 13'h1800, 8'h66);
      endcase
      exp_v = exp_q.pop_front();
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_v) begin
        n_fail++;
        $display("FAIL bypass_%0d: valid=%0b data=%02h, need 1 %02h", i, rd_valid, rd_data, exp_v);
      end
    end
  endtask

  task automatic test_clear();
    int busy_cnt = 0, done_cnt = 0, done_cyc = -1;
    logic ready_at_done = 1'b0;
    logic [12:0] a1 [4] = '{13'h17FF, 13'h1800, 13'h1AFF, 13'd0};
    logic [12:0] a0 [3] = '{13'h17FF, 13'h1AFF, 13'd0};
    set_disp(1'b1);
    cpu_write(1'b1, 13'h17FF, 8'hFF);
    cpu_write(1'b1, 13'h1800, 8'h12);
    cpu_write(1'b1, 13'h1AFF, 8'h34);
    cpu_write(1'b1, 13'd4999, 8'h99);
    cpu_write(1'b1, 13'd6499, 8'h99);
    cpu_write(1'b1, 13'd0,    8'h5E);
    cpu_write(1'b0, 13'h17FF, 8'h77);
    cpu_write(1'b0, 13'h1AFF, 8'h43);
    clr_bank = 1'b1; clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int cyc = 1; cyc <= 7000; cyc++) begin
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        n_checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp_v) begin
          n_fail++;
          $display("FAIL read_during_clear@%0d: valid=%0b data=%02h, need 1 %02h", cyc, rd_valid, rd_data, exp_v);
        end
      end
      rd_en = 1'b0; wr_en = 1'b0; clr_req = 1'b0;
      if (clr_busy) busy_cnt++;
      if (clr_done) begin done_cnt++; done_cyc = cyc; ready_at_done = wr_ready; end
      if (cyc == 100) begin clr_req = 1'b1; clr_bank = 1'b0; end
      if (cyc == 200) begin
        n_checks++;
        if (wr_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL ready_during_clear: wr_ready=%0b, need 0", wr_ready);
        end
        wr_en = 1'b1; wr_bank = 1'b0; wr_addr = 13'h17FF; wr_data = 8'hEE;
      end
      if (cyc == 300)  begin rd_en = 1'b1; rd_addr = 13'd0;    exp_q.push_back(8'h00); end
      if (cyc == 5000) begin rd_en = 1'b1; rd_addr = 13'd4999; exp_q.push_back(8'h00); end
      if (cyc == 6500) begin rd_en = 1'b1; rd_addr = 13'd6499; exp_q.push_back(8'h38); end
      tick();
    end
    foreach (model[k]) if (k >= 8192) model[k] = (k - 8192 < 6144) ? 8'h00 : 8'h38;
    n_checks++;
    if (busy_cnt != 6912 || done_cnt != 1 || done_cyc != 6913 || ready_at_done !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_timing: busy=%0d done=%0d at %0d ready=%0b, need 6912 1 6913 1",
               busy_cnt, done_cnt, done_cyc, ready_at_done);
    end
    for (int i = 0; i < 4; i++) begin
      issue_read(a1[i], model[key(1'b1, a1[i])]);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_v) begin
        n_fail++;
        $display("FAIL cleared_bank1[%0h]: valid=%0b data=%02h, need 1 %02h", a1[i], rd_valid, rd_data, exp_v);
      end
    end
    set_disp(1'b0);
    for (int i = 0; i < 3; i++) begin
      issue_read(a0[i], model[key(1'b0, a0[i])]);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_v) begin
        n_fail++;
        $display("FAIL bank0_untouched[%0h]: valid=%0b data=%02h, need 1 %02h", a0[i], rd_valid, rd_data, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int bad = 0;
    logic [12:0] ra [3] = '{13'd4000, 13'd100, 13'd88};
    cpu_write(1'b1, 13'd4000, 8'h5C);
    cpu_write(1'b1, 13'd100,  8'h66);
    cpu_write(1'b1, 13'd88,   8'h3C);
    clr_bank = 1'b1; clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int cyc = 1; cyc < 3000; cyc++) tick();
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (clr_busy !== 1'b0 || wr_ready !== 1'b1 || clr_done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_mid_clear: busy=%0b ready=%0b done=%0b, need 0 1 0", clr_busy, wr_ready, clr_done);
    end
    tick(); tick();
    reset_n = 1'b1;
    cur_disp = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (clr_done !== 1'b0 || clr_busy !== 1'b0 || wr_ready !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL no_done_after_reset: %0d bad cycles, need 0", bad);
    end
    model[key(1'b1, 13'd100)] = 8'h00;
    model[key(1'b1, 13'd88)]  = 8'h00;
    write_and_read(1'b0, 13'd7000, 8'hFF);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== exp_v) begin
      n_fail++;
      $display("FAIL oob_write_read: valid=%0b data=%02h, need 1 %02h", rd_valid, rd_data, exp_v);
    end
    set_disp(1'b1);
    for (int i = 0; i < 3; i++) begin
      issue_read(ra[i], model[key(1'b1, ra[i])]);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_v) begin
        n_fail++;
        $display("FAIL partial_clear[%0d]: valid=%0b data=%02h, need 1 %02h", ra[i], rd_valid, rd_data, exp_v);
      end
    end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_write_read();
    test_bank_switch();
    test_bypass();
    test_clear();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
